softmax_sched: RTL

SOFTMAX_SCHED -- requirements
Module: softmax_sched

---
 rtl/softmax_pkg.sv | 45 ++++
 rtl/softmax_sched_if.sv | 43 ++++
 rtl/softmax_sched_fifo.sv | 60 ++++++
 rtl/softmax_sched.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// ============================================================================
//  Module      : softmax_pkg
//  Description : Shared types and constants for the softmax request scheduler:
//                request type codes, FSM state encoding, default issue gaps,
//                field widths and the issue-word formatting helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package softmax_pkg;

  // Request type codes, also bit [12] of the issued word
  localparam logic SYS_TYPE = 1'b1;
  localparam logic BR_TYPE  = 1'b0;

  // Default minimum spacing (cycles) between an issue and the next issue
  localparam int DEF_SYS_GAP = 14;
  localparam int DEF_BR_GAP  = 70;

  // Field widths
  localparam int SYS_IDX_W = 9;
  localparam int BR_IDX_W  = 12;
  localparam int DATA_W    = 13;
  localparam int CNT_W     = 16;
  localparam int WAIT_W    = 16;

  // Scheduler FSM
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // SYS index is zero-extended to 12 bits under the type bit
  function automatic logic [DATA_W-1:0] fmt_sys(input logic [SYS_IDX_W-1:0] idx);
    return {SYS_TYPE, 3'b000, idx};
  endfunction

  function automatic logic [DATA_W-1:0] fmt_br(input logic [BR_IDX_W-1:0] idx);
    return {BR_TYPE, idx};
  endfunction

endpackage

`default_nettype wire

// File: rtl/softmax_sched_if.sv
// ============================================================================
//  Module      : softmax_sched_if
//  Description : Request/issue/status bundle of the softmax scheduler.
//    Requests : iSys_valid/iSys_idx/oSys_ready, iBr_valid/iBr_idx/oBr_ready
//    Issue    : oFIFO_valid (one-cycle strobe), oFIFO_data (13-bit word)
//    Status   : iAbnormal, iClr_cnt, oBusy, oSys_abn_cnt, oBr_abn_cnt
//  The slave modport is the scheduler side, master is the requester/engine.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface softmax_sched_if;
  import softmax_pkg::*;

  logic                 iSys_valid;
  logic [SYS_IDX_W-1:0] iSys_idx;
  logic                 oSys_ready;
  logic                 iBr_valid;
  logic [BR_IDX_W-1:0]  iBr_idx;
  logic                 oBr_ready;
  logic                 oFIFO_valid;
  logic [DATA_W-1:0]    oFIFO_data;
  logic                 iAbnormal;
  logic                 iClr_cnt;
  logic                 oBusy;
  logic [CNT_W-1:0]     oSys_abn_cnt;
  logic [CNT_W-1:0]     oBr_abn_cnt;

  modport master (
    output iSys_valid, iSys_idx, iBr_valid, iBr_idx, iAbnormal, iClr_cnt,
    input  oSys_ready, oBr_ready, oFIFO_valid, oFIFO_data, oBusy,
           oSys_abn_cnt, oBr_abn_cnt
  );

  modport slave (
    input  iSys_valid, iSys_idx, iBr_valid, iBr_idx, iAbnormal, iClr_cnt,
    output oSys_ready, oBr_ready, oFIFO_valid, oFIFO_data, oBusy,
           oSys_abn_cnt, oBr_abn_cnt
  );

endinterface

`default_nettype wire

// File: rtl/softmax_sched_fifo.sv
// ============================================================================
//  Module      : sched_fifo
//  Description : Small synchronous FIFO holding pending request indices.
//    clk, resetn      : clock, asynchronous active-low reset (empties FIFO)
//    push, push_data  : write request, ignored while full
//    pop, head        : read request, head is the oldest entry (show-ahead)
//    full, empty      : occupancy flags, derived from registered pointers only
//  DEPTH must be a power of two and at least 2.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sched_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra wrap bit distinguishes full from empty
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/softmax_sched.sv
// ============================================================================
//  Module      : softmax_sched
//  Description : Queues SYS and BR softmax requests and issues them one at a
//                time to the softmax engine, round-robin between types, with
//                a per-type minimum spacing between issues. Counts abnormal
//                pulses reported by the engine against the in-flight type.
//    clk, resetn : clock, asynchronous active-low reset
//    bus         : softmax_sched_if.slave (requests, issue strobe, status)
//  SYS_GAP/BR_GAP must be at least 3; QDEPTH a power of two, at least 2.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module softmax_sched
  import softmax_pkg::*;
#(
  parameter int SYS_GAP = DEF_SYS_GAP,
  parameter int BR_GAP  = DEF_BR_GAP,
  parameter int QDEPTH  = 4
) (
  input  logic           clk,
  input  logic           resetn,
  softmax_sched_if.slave bus
);

  // IDLE and ISSUE take one cycle each, so WAIT covers the rest of the gap
  localparam logic [WAIT_W-1:0] SYS_WAIT = WAIT_W'(SYS_GAP - 2);
  localparam logic [WAIT_W-1:0] BR_WAIT  = WAIT_W'(BR_GAP - 2);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  // Request queues
  logic                 sys_push, sys_pop, sys_full, sys_empty;
  logic [SYS_IDX_W-1:0] sys_head;
  logic                 br_push, br_pop, br_full, br_empty;
  logic [BR_IDX_W-1:0]  br_head;

  // FSM and issue registers
  state_t              state, state_next;
  logic                last_grant, last_grant_next;
  logic [WAIT_W-1:0]   wait_cnt, wait_next;
  logic                fifo_valid, fifo_valid_next;
  logic [DATA_W-1:0]   fifo_data, fifo_data_next;

  // Abnormal counters
  logic                abn_in_wait;
  logic [CNT_W-1:0]    sys_abn_cnt, sys_abn_next;
  logic [CNT_W-1:0]    br_abn_cnt, br_abn_next;

  // --------------------------------------------------------------------------
  // Queues: ready depends only on the registered full flag
  // --------------------------------------------------------------------------
  assign sys_push       = bus.iSys_valid && !sys_full;
  assign br_push        = bus.iBr_valid && !br_full;
  assign bus.oSys_ready = !sys_full;
  assign bus.oBr_ready  = !br_full;

  sched_fifo #(
    .WIDTH (SYS_IDX_W),
    .DEPTH (QDEPTH)
  ) u_sys_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (sys_push),
    .push_data (bus.iSys_idx),
    .pop       (sys_pop),
    .head      (sys_head),
    .full      (sys_full),
    .empty     (sys_empty)
  );

  sched_fifo #(
    .WIDTH (BR_IDX_W),
    .DEPTH (QDEPTH)
  ) u_br_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (br_push),
    .push_data (bus.iBr_idx),
    .pop       (br_pop),
    .head      (br_head),
    .full      (br_full),
    .empty     (br_empty)
  );

  // --------------------------------------------------------------------------
  // Scheduler FSM: next state and outputs
  // The issue word and strobe are registered while leaving IDLE, so they are
  // valid exactly during the ISSUE cycle. last_grant doubles as the in-flight
  // type while in ISSUE/WAIT.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    wait_next       = wait_cnt;
    fifo_valid_next = 1'b0;
    fifo_data_next  = fifo_data;
    sys_pop         = 1'b0;
    br_pop          = 1'b0;

    case (state)
      ST_IDLE: begin
        // SYS wins when it is alone or when BR was granted last
        if (!sys_empty && (br_empty || (last_grant == BR_TYPE))) begin
          sys_pop         = 1'b1;
          last_grant_next = SYS_TYPE;
          fifo_valid_next = 1'b1;
          fifo_data_next  = fmt_sys(sys_head);
          state_next      = ST_ISSUE;
        end else if (!br_empty) begin
          br_pop          = 1'b1;
          last_grant_next = BR_TYPE;
          fifo_valid_next = 1'b1;
          fifo_data_next  = fmt_br(br_head);
          state_next      = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        wait_next  = (last_grant == SYS_TYPE) ? SYS_WAIT : BR_WAIT;
        state_next = ST_WAIT;
      end

      ST_WAIT: begin
        if (wait_cnt <= WAIT_ONE) begin
          wait_next  = '0;
          state_next = ST_IDLE;
        end else begin
          wait_next  = wait_cnt - WAIT_ONE;
        end
      end

      default: begin
        wait_next  = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Abnormal counters: clear has priority, increments saturate
  // --------------------------------------------------------------------------
  assign abn_in_wait = bus.iAbnormal && (state == ST_WAIT);

  always_comb begin
    sys_abn_next = sys_abn_cnt;
    br_abn_next  = br_abn_cnt;
    if (bus.iClr_cnt) begin
      sys_abn_next = '0;
      br_abn_next  = '0;
    end else if (abn_in_wait) begin
      if (last_grant == SYS_TYPE) begin
        if (sys_abn_cnt != CNT_MAX) sys_abn_next = sys_abn_cnt + CNT_ONE;
      end else begin
        if (br_abn_cnt != CNT_MAX) br_abn_next = br_abn_cnt + CNT_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      last_grant  <= BR_TYPE;
      wait_cnt    <= '0;
      fifo_valid  <= 1'b0;
      fifo_data   <= '0;
      sys_abn_cnt <= '0;
      br_abn_cnt  <= '0;
    end else begin
      state       <= state_next;
      last_grant  <= last_grant_next;
      wait_cnt    <= wait_next;
      fifo_valid  <= fifo_valid_next;
      fifo_data   <= fifo_data_next;
      sys_abn_cnt <= sys_abn_next;
      br_abn_cnt  <= br_abn_next;
    end
  end

  assign bus.oFIFO_valid  = fifo_valid;
  assign bus.oFIFO_data   = fifo_data;
  assign bus.oBusy        = (state != ST_IDLE);
  assign bus.oSys_abn_cnt = sys_abn_cnt;
  assign bus.oBr_abn_cnt  = br_abn_cnt;

endmodule

`default_nettype wire
